mem_store_unit: RTL and testbench
=================================

# mem_store_unit

Multi-cycle store sequencer for the single-cycle MIPS datapath. It writes a register value into the 64×32 block RAM, the write-side counterpart of the existing load path (RAM `douta` → register `W_Data`). The block computes `base + sign-extended offset`, checks alignment and range, and performs word, halfword or byte stores. Sub-word stores use read-modify-write on the word-wide RAM. It sits between the register file read ports (RS/RT data) and the RAM port A.

## Interface
Parameters:
- `ADDR_W`, default 6: RAM word-address width. The RAM depth is 2^ADDR_W words.

Ports:
- `clk`, in, 1: sole clock. All state changes on its rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request. Sampled only in IDLE.
- `size`, in, 2: store size. 00 = byte, 01 = half, 10 = word, 11 = reserved (flags error).
- `base`, in, 32: base address, taken from the RS register data.
- `offset`, in, 16: immediate. Sign-extended to 32 bits.
- `store_data`, in, 32: value to store, taken from the RT register data. The low byte or halfword is used for sub-word stores.
- `busy`, out, 1: high whenever the block is not in IDLE.
- `done`, out, 1: one-cycle pulse at completion, successful or not.
- `err`, out, 1: valid with `done`. 1 means the store was rejected and no write took place.
- `mem_we`, out, 1: RAM write enable. High in exactly one cycle per successful store.
- `mem_addr`, out, ADDR_W: RAM word address.
- `mem_din`, out, 32: RAM write data.
- `mem_dout`, in, 32: RAM read data. Synchronous read with 1-cycle latency.

## Operation
- **Input capture:** in IDLE with `start`=1, the block latches `size`, `base`, `offset` and `store_data`. `start` is ignored when `busy`=1.
- **Effective address:** ea = base + {{16{offset[15]}}, offset}, computed modulo 2^32. The word index is ea[ADDR_W+1:2] and the lane is ea[1:0].
- **Error conditions:** `err` is set when any of the following holds:
  - size = 11;
  - size = half and ea[0] = 1;
  - size = word and ea[1:0] ≠ 0;
  - ea[31:ADDR_W+2] ≠ 0.
- **Byte merge:** lane k gets bits [8k+7:8k] ← store_data[7:0].
- **Half merge:** ea[1] = h selects bits [16h+15:16h] ← store_data[15:0]. The layout is little-endian.
- **FSM states:** IDLE, CALC, RD, WAIT, WR, DONE.
  - IDLE → CALC on `start`.
  - CALC computes and registers ea, then checks for errors:
    - error: go to DONE with `err` latched;
    - word store: go to WR;
    - byte or half store: go to RD.
  - RD drives `mem_addr` with `mem_we`=0, then goes to WAIT.
  - WAIT registers the merge of `mem_dout` with the store data, then goes to WR.
  - WR holds `mem_we`=1 with `mem_addr` and `mem_din` stable, then goes to DONE.
  - DONE pulses `done`, drives `err`, then returns to IDLE.
- **Idle outputs:** `mem_addr` and `mem_din` hold their last values outside RD/WR. `mem_we` is 0 in every state except WR.

## Timing
- **Reset values:** `busy`=0, `done`=0, `err`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, state = IDLE.
- **Latency:** `start` is sampled at edge E0. `done` is high in the cycle after:
  - word store: E2 (3 cycles);
  - byte or half store: E4 (5 cycles);
  - error: E1 (2 cycles).
- **Back-to-back:** a new request is accepted on the edge that leaves DONE only if the state is already IDLE, so at least one IDLE cycle separates operations.
- **Reset mid-operation:** the block returns to IDLE immediately and `mem_we` drops asynchronously. No write occurs unless the WR edge has already passed. `done` does not pulse for the aborted operation.
- **`err` width:** `err` is meaningful only while `done`=1, and is 0 otherwise.

## Structure
- **Shared package (`mips_pkg`):**
  - size codes `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - FSM state encoding (3-bit);
  - `RAM_ADDR_W` = 6.
- **Sub-module `store_merge`:** combinational. Inputs are old word, store data, size and lane. Output is the merged word. It is reusable by a later sub-word load extractor.

## Test plan
- **Word store:** RAM[5] = 0, base = 0x10, offset = 0x0004, size = word, data = 0x12345678 → one `mem_we` pulse with `mem_addr`=5; RAM[5] = 0x12345678; `done` 3 cycles after `start`; `err`=0.
- **Byte store:** RAM[5] = 0x12345678, base = 0x14, offset = 0x0001, size = byte, data = 0x000000AB → RAM[5] = 0x1234AB78; `done` at 5 cycles.
- **Half store:** RAM[5] = 0x12345678, ea = 0x16, size = half, data = 0xFFFFBEEF → RAM[5] = 0xBEEF5678.
- **Negative offset:** base = 0x20, offset = 0xFFFC, size = word → `mem_addr`=7.
- **Errors:**
  - size = word with ea = 0x16;
  - size = byte with base = 0x100;
  - size = 11.
  - Each case → `done` at 2 cycles with `err`=1; `mem_we` never asserted; RAM unchanged.
- **Reset and busy:**
  - `Reset` pulsed during WAIT of a byte store → `mem_we` stays 0, RAM unchanged, `busy`=0, no `done`.
  - `start` held high through an operation → exactly one store per IDLE acceptance.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared size codes, store FSM encoding and RAM geometry for the MIPS datapath.
package mips_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int RAM_ADDR_W = 6;
    typedef enum logic [2:0] {S_IDLE, S_CALC, S_RD, S_WAIT, S_WR, S_DONE} state_t;
endpackage

// File: rtl/store_merge.sv
// store_merge: inserts a byte or halfword into a little-endian 32-bit word at the given lane.
module store_merge
    import mips_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_data,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_word
);
    always_comb begin
        o_word = i_data;
        if (i_size == SZ_BYTE) begin
            o_word = i_old;
            o_word[{i_lane, 3'b000} +: 8] = i_data[7:0];
        end else if (i_size == SZ_HALF) begin
            o_word = i_old;
            o_word[{i_lane[1], 4'b0000} +: 16] = i_data[15:0];
        end
    end
endmodule

// File: rtl/mem_store_unit.sv
// mem_store_unit: multi-cycle word/half/byte store sequencer with alignment and range checks.
module mem_store_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [31:0]       base,
    input  logic [15:0]       offset,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);
    state_t              r_state, w_next;
    logic [1:0]          r_size, r_lane;
    logic [31:0]         r_base, r_data, r_mem_din;
    logic [15:0]         r_offset;
    logic                r_err;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         w_ea, w_merged;
    logic                w_bad;
    assign w_ea  = r_base + {{16{r_offset[15]}}, r_offset};
    assign w_bad = (r_size == 2'b11) || (r_size == SZ_HALF && w_ea[0]) ||
                   (r_size == SZ_WORD && w_ea[1:0] != 2'b00) || ((w_ea >> (ADDR_W + 2)) != 32'd0);
    store_merge u_merge (
        .i_old  (mem_dout),
        .i_data (r_data),
        .i_size (r_size),
        .i_lane (r_lane),
        .o_word (w_merged)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_CALC : S_IDLE;
            S_CALC:  w_next = w_bad ? S_DONE : (r_size == SZ_WORD ? S_WR : S_RD);
            S_RD:    w_next = S_WAIT;
            S_WAIT:  w_next = S_WR;
            S_WR:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
    // mem_we decodes state directly so an async reset drops it without waiting for a clock
    assign busy     = r_state != S_IDLE;
    assign done     = r_state == S_DONE;
    assign err      = done && r_err;
    assign mem_we   = r_state == S_WR;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_size     <= 2'b00;
            r_base     <= 32'd0;
            r_offset   <= 16'd0;
            r_data     <= 32'd0;
            r_err      <= 1'b0;
            r_lane     <= 2'b00;
            r_mem_addr <= '0;
            r_mem_din  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_size   <= size;
                r_base   <= base;
                r_offset <= offset;
                r_data   <= store_data;
            end
            if (r_state == S_CALC) begin
                r_err  <= w_bad;
                r_lane <= w_ea[1:0];
                if (!w_bad) begin
                    r_mem_addr <= w_ea[ADDR_W+1:2];
                    if (r_size == SZ_WORD)
                        r_mem_din <= r_data;
                end
            end
            if (r_state == S_WAIT)
                r_mem_din <= w_merged;
        end
    end
endmodule

// File: tb/tb_mem_store_unit.sv
// tb_mem_store_unit: directed and random stores against a word-array reference memory model.
module tb_mem_store_unit;
    logic        clk, Reset, start;
    logic [1:0]  size;
    logic [31:0] base, store_data, mem_din, mem_dout;
    logic [15:0] offset;
    logic        busy, done, err, mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] ram [64];
    logic [31:0] ref_mem [64];
    int n_cmp = 0, n_fail = 0;

    mem_store_unit #(.ADDR_W(6)) dut (
        .clk(clk), .Reset(Reset), .start(start), .size(size), .base(base),
        .offset(offset), .store_data(store_data), .busy(busy), .done(done),
        .err(err), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ram(input string tag);
        int bad = 0;
        for (int i = 0; i < 64; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic do_store(input logic [1:0] sz, input logic [31:0] b, input logic [15:0] off,
                            input logic [31:0] d, input bit hold);
        logic [31:0] ea, exp_w, we_addr, we_din;
        logic        e, err_obs, seen;
        int          lat, exp_lat, we_cnt;
        ea = b + {{16{off[15]}}, off};
        e = (sz == 2'd3) || (sz == 2'd1 && ea[0]) || (sz == 2'd2 && ea[1:0] != 0) || (ea >= 32'd256);
        exp_lat = e ? 2 : (sz == 2'd2 ? 3 : 5);
        exp_w = 0;
        if (!e) begin
            exp_w = ref_mem[ea[7:2]];
            if (sz == 2'd0)
                exp_w = (exp_w & ~(32'hFF << (8 * ea[1:0]))) | ((d & 32'hFF) << (8 * ea[1:0]));
            else if (sz == 2'd1)
                exp_w = (exp_w & ~(32'hFFFF << (16 * ea[1]))) | ((d & 32'hFFFF) << (16 * ea[1]));
            else
                exp_w = d;
            ref_mem[ea[7:2]] = exp_w;
        end
        @(negedge clk);
        start = 1; size = sz; base = b; offset = off; store_data = d;
        lat = 0; we_cnt = 0; seen = 0; err_obs = 0; we_addr = 0; we_din = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (!hold) start = 0;
            if (mem_we) begin
                we_cnt++;
                we_addr = 32'(mem_addr);
                we_din = mem_din;
            end
            if (done) begin
                lat = n;
                err_obs = err;
                seen = 1;
                break;
            end
        end
        start = 0;
        chk("done_seen", 32'(seen), 1);
        chk("latency", lat, exp_lat);
        chk("err", 32'(err_obs), 32'(e));
        chk("we_count", we_cnt, e ? 0 : 1);
        if (!e) begin
            chk("we_addr", we_addr, 32'(ea[7:2]));
            chk("we_din", we_din, exp_w);
        end
        @(negedge clk);
        chk("after_busy", 32'(busy), 0);
        chk("after_done", 32'(done), 0);
        chk("after_err", 32'(err), 0);
        check_ram("ram_match");
    endtask

    initial begin
        int we_cnt, done_cnt;
        Reset = 1; start = 0; size = 0; base = 0; offset = 0; store_data = 0;
        for (int i = 0; i < 64; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_din", mem_din, 0);
        Reset = 0;
        @(negedge clk);
        ram[5] = 0; ref_mem[5] = 0;
        do_store(2'd2, 32'h10, 16'h0004, 32'h12345678, 0);
        chk("word_ram5", ram[5], 32'h12345678);
        do_store(2'd0, 32'h14, 16'h0001, 32'h000000AB, 0);
        chk("byte_ram5", ram[5], 32'h1234AB78);
        @(negedge clk);
        ram[5] = 32'h12345678; ref_mem[5] = 32'h12345678;
        do_store(2'd1, 32'h16, 16'h0000, 32'hFFFFBEEF, 0);
        chk("half_ram5", ram[5], 32'hBEEF5678);
        do_store(2'd2, 32'h20, 16'hFFFC, 32'hCAFEF00D, 0);
        chk("neg_ram7", ram[7], 32'hCAFEF00D);
        do_store(2'd2, 32'h16, 16'h0000, 32'h11111111, 0);
        do_store(2'd0, 32'h100, 16'h0000, 32'h22222222, 0);
        do_store(2'd3, 32'h10, 16'h0000, 32'h33333333, 0);
        do_store(2'd2, 32'h40, 16'h0008, 32'hA5A5A5A5, 1);
        // abort a byte store while it waits on the RAM read
        @(negedge clk);
        start = 1; size = 2'd0; base = 32'h30; offset = 16'h0002; store_data = 32'h000000EE;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        Reset = 1;
        #1;
        chk("abort_we", 32'(mem_we), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        @(negedge clk);
        Reset = 0;
        we_cnt = 0; done_cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (done) done_cnt++;
        end
        chk("abort_no_we", we_cnt, 0);
        chk("abort_no_done", done_cnt, 0);
        check_ram("abort_ram");
        for (int k = 0; k < 40; k++)
            do_store(2'($urandom_range(0, 3)), 32'($urandom_range(0, 300)),
                     16'($urandom_range(0, 60)) - 16'd30, $urandom, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
